// File: rtl/instmem_loader_ctrl_if.sv
// Interface bundling the fetch, loader-control, byte-stream and instruction
// memory signals of instmem_loader_ctrl.
//   slave  : the controller side (drives f_data/f_ready, byte_ready, load
//            status and the memory write/address/data lines).
//   master : the environment side (fetch stage, loader host, byte source
//            and the memory's combinational read data).
interface instmem_loader_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_data;
    logic              f_ready;
    logic              ld_start;
    logic              ld_abort;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W-1:0] ld_len;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              ld_busy;
    logic              ld_done;
    logic [ADDR_W-1:0] ld_count;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_datain;
    logic [DATA_W-1:0] mem_dataout;

    modport slave (
        input  f_req, f_addr, ld_start, ld_abort, ld_base, ld_len,
               byte_valid, byte_data, mem_dataout,
        output f_data, f_ready, byte_ready, ld_busy, ld_done, ld_count,
               mem_write, mem_addr, mem_datain
    );

    modport master (
        output f_req, f_addr, ld_start, ld_abort, ld_base, ld_len,
               byte_valid, byte_data, mem_dataout,
        input  f_data, f_ready, byte_ready, ld_busy, ld_done, ld_count,
               mem_write, mem_addr, mem_datain
    );
endinterface

// File: rtl/instmem_loader_ctrl.sv
// Instruction-memory loader controller.
// Arbitrates a single-port instruction memory between the fetch path
// (zero-latency combinational reads while idle) and a program loader that
// assembles an incoming byte stream into DATA_W-bit words and writes them to
// consecutive addresses starting at ld_base. Fetch is stalled for the whole
// load.
// Ports:
//   clk   : rising-edge system clock
//   reset : asynchronous, active-low reset
//   bus   : instmem_loader_ctrl_if.slave (fetch, load control, byte stream,
//           memory bus)
module instmem_loader_ctrl #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    instmem_loader_ctrl_if.slave  bus
);
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned IDX_W  = $clog2(NBYTES) + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_shift;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_inc;
    logic              last_byte;
    logic              mem_write_q;
    logic              byte_ready_q;
    logic              ld_busy_q;
    logic              ld_done_q;
    logic              fetch_en_q;

    assign count_inc = count_q + ADDR_W'(1);
    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

    // Shift the incoming byte in so that after NBYTES bytes the first one
    // sits in the most (big-endian) or least (little-endian) significant byte.
    always_comb begin
        if (BIG_ENDIAN) begin
            word_shift = (word_q << 8) | DATA_W'(bus.byte_data);
        end else begin
            word_shift = (word_q >> 8) | (DATA_W'(bus.byte_data) << (DATA_W - 8));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.ld_start) begin
                    state_d = (bus.ld_len == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (bus.ld_abort) begin
                    state_d = IDLE;
                end else if (bus.byte_valid && last_byte) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.ld_abort) begin
                    state_d = IDLE;
                end else if (count_inc == len_q) begin
                    state_d = DONE;
                end else begin
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status/strobe outputs are registered from the next state, so they line
    // up with state_q; fetch_en_q also keeps f_ready low while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            word_q       <= '0;
            base_q       <= '0;
            len_q        <= '0;
            count_q      <= '0;
            mem_write_q  <= 1'b0;
            byte_ready_q <= 1'b0;
            ld_busy_q    <= 1'b0;
            ld_done_q    <= 1'b0;
            fetch_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_write_q  <= (state_d == WRITE);
            byte_ready_q <= (state_d == COLLECT);
            ld_busy_q    <= (state_d != IDLE);
            ld_done_q    <= (state_d == DONE);
            fetch_en_q   <= (state_d == IDLE);
            case (state_q)
                IDLE: begin
                    if (bus.ld_start) begin
                        base_q  <= bus.ld_base;
                        len_q   <= bus.ld_len;
                        count_q <= '0;
                        idx_q   <= '0;
                        word_q  <= '0;
                    end
                end
                COLLECT: begin
                    if (bus.ld_abort) begin
                        idx_q  <= '0;
                        word_q <= '0;
                    end else if (bus.byte_valid) begin
                        word_q <= word_shift;
                        idx_q  <= idx_q + IDX_W'(1);
                    end
                end
                WRITE: begin
                    // An abort here still lets the write complete and count.
                    count_q <= count_inc;
                    idx_q   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.f_ready    = bus.f_req & fetch_en_q;
    assign bus.f_data     = bus.mem_dataout;
    assign bus.byte_ready = byte_ready_q;
    assign bus.ld_busy    = ld_busy_q;
    assign bus.ld_done    = ld_done_q;
    assign bus.ld_count   = count_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_write_q ? (base_q + count_q) : bus.f_addr;
    assign bus.mem_datain = word_q;
endmodule

// File: tb/tb_instmem_loader_ctrl.sv
// Directed bench for instmem_loader_ctrl: a behavioural 64K x 32 memory with
// combinational read and synchronous write, a negedge monitor logging writes
// and status pulses, and one task per scenario.
module tb_instmem_loader_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instmem_loader_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    instmem_loader_ctrl #(.ADDR_W(16), .DATA_W(32), .BIG_ENDIAN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model
    logic [31:0] mem [0:65535];
    logic        pre_we;
    logic [15:0] pre_a;
    logic [31:0] pre_d;
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_datain;
        else if (pre_we) mem[pre_a] <= pre_d;
    end
    assign bus.mem_dataout = mem[bus.mem_addr];

    // Monitor
    int          cyc = 0;
    int          n_wr = 0;
    int          n_done = 0;
    int          n_br = 0;
    int          n_fbusy = 0;
    int          last_wr_cyc = 0;
    int          done_cyc = 0;
    logic [15:0] wa [0:63];
    logic [31:0] wd [0:63];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_write === 1'b1) begin
            if (n_wr < 64) begin
                wa[n_wr] <= bus.mem_addr;
                wd[n_wr] <= bus.mem_datain;
            end
            n_wr <= n_wr + 1;
            last_wr_cyc <= cyc;
        end
        if (bus.ld_done === 1'b1) begin
            n_done <= n_done + 1;
            done_cyc <= cyc;
        end
        if (bus.byte_ready === 1'b1) n_br <= n_br + 1;
        if (bus.f_ready === 1'b1 && bus.ld_busy === 1'b1) n_fbusy <= n_fbusy + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [15:0] base, input logic [15:0] len);
        bus.ld_start = 1'b1;
        bus.ld_base  = base;
        bus.ld_len   = len;
        step();
        bus.ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.byte_ready === 1'b1) got = 1;
            step();
        end
        bus.byte_valid = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL send_byte_timeout byte=%h byte_ready never seen", b);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.ld_busy === 1'b0) ok = 1;
            step();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_idle_timeout ld_busy still %b", name, bus.ld_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.f_req = 1'b1;
        bus.f_addr = 16'h0020;
        bus.ld_start = 1'b0;
        bus.ld_abort = 1'b0;
        bus.ld_base = '0;
        bus.ld_len = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data = '0;
        pre_we = 1'b0;
        pre_a = '0;
        pre_d = '0;
        #2;
        total++; if (bus.mem_write !== 1'b0) begin bad++; $display("FAIL rst_mem_write got=%b exp=0", bus.mem_write); end
        total++; if (bus.ld_done !== 1'b0) begin bad++; $display("FAIL rst_ld_done got=%b exp=0", bus.ld_done); end
        total++; if (bus.ld_busy !== 1'b0) begin bad++; $display("FAIL rst_ld_busy got=%b exp=0", bus.ld_busy); end
        total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL rst_byte_ready got=%b exp=0", bus.byte_ready); end
        total++; if (bus.f_ready !== 1'b0) begin bad++; $display("FAIL rst_f_ready got=%b exp=0", bus.f_ready); end
        total++; if (bus.ld_count !== 16'h0000) begin bad++; $display("FAIL rst_ld_count got=%h exp=0000", bus.ld_count); end
        // Preload a word for the fetch checks while reset is held.
        pre_we = 1'b1; pre_a = 16'h0020; pre_d = 32'hCAFEBABE;
        step();
        pre_we = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_load2();
        int w0 = n_wr;
        int d0 = n_done;
        int f0 = n_fbusy;
        logic [7:0] bytes [0:7];
        bytes[0] = 8'h6F; bytes[1] = 8'h7A; bytes[2] = 8'h00; bytes[3] = 8'h0A;
        bytes[4] = 8'hD8; bytes[5] = 8'h3B; bytes[6] = 8'hC0; bytes[7] = 8'h00;
        @(negedge clk);
        total++; if (bus.f_ready !== 1'b1) begin bad++; $display("FAIL load2_pre_f_ready got=%b exp=1", bus.f_ready); end
        total++; if (bus.f_data !== 32'hCAFEBABE) begin bad++; $display("FAIL load2_pre_f_data got=%h exp=cafebabe", bus.f_data); end
        step();
        start_load(16'h0010, 16'd2);
        for (int i = 0; i < 8; i++) send_byte(bytes[i]);
        wait_idle("load2");
        total++; if (n_wr - w0 !== 2) begin bad++; $display("FAIL load2_nwrites got=%0d exp=2", n_wr - w0); end
        total++; if (wa[w0] !== 16'h0010 || wd[w0] !== 32'h6F7A000A) begin bad++; $display("FAIL load2_wr0 got=%h:%h exp=0010:6f7a000a", wa[w0], wd[w0]); end
        total++; if (wa[w0+1] !== 16'h0011 || wd[w0+1] !== 32'hD83BC000) begin bad++; $display("FAIL load2_wr1 got=%h:%h exp=0011:d83bc000", wa[w0+1], wd[w0+1]); end
        total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL load2_ndone got=%0d exp=1", n_done - d0); end
        total++; if (done_cyc !== last_wr_cyc + 1) begin bad++; $display("FAIL load2_done_timing got=%0d exp=%0d", done_cyc, last_wr_cyc + 1); end
        total++; if (bus.ld_count !== 16'd2) begin bad++; $display("FAIL load2_ld_count got=%h exp=0002", bus.ld_count); end
        total++; if (n_fbusy - f0 !== 0) begin bad++; $display("FAIL load2_fetch_stall got=%0d exp=0", n_fbusy - f0); end
        @(negedge clk);
        total++; if (bus.f_ready !== 1'b1) begin bad++; $display("FAIL load2_post_f_ready got=%b exp=1", bus.f_ready); end
        total++; if (bus.f_data !== 32'hCAFEBABE) begin bad++; $display("FAIL load2_post_f_data got=%h exp=cafebabe", bus.f_data); end
        step();
        bus.f_addr = 16'h0011;
        @(negedge clk);
        total++; if (bus.f_data !== 32'hD83BC000) begin bad++; $display("FAIL load2_fetch_loaded got=%h exp=d83bc000", bus.f_data); end
        step();
    endtask

    task automatic test_zero_len();
        int w0 = n_wr;
        int d0 = n_done;
        int b0 = n_br;
        start_load(16'h0200, 16'd0);
        @(negedge clk);
        total++; if (bus.ld_done !== 1'b1) begin bad++; $display("FAIL zlen_done_pulse got=%b exp=1", bus.ld_done); end
        step();
        step();
        step();
        total++; if (bus.ld_busy !== 1'b0) begin bad++; $display("FAIL zlen_busy got=%b exp=0", bus.ld_busy); end
        total++; if (n_wr - w0 !== 0) begin bad++; $display("FAIL zlen_nwrites got=%0d exp=0", n_wr - w0); end
        total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL zlen_ndone got=%0d exp=1", n_done - d0); end
        total++; if (n_br - b0 !== 0) begin bad++; $display("FAIL zlen_byte_ready got=%0d exp=0", n_br - b0); end
        total++; if (bus.ld_count !== 16'd0) begin bad++; $display("FAIL zlen_ld_count got=%h exp=0000", bus.ld_count); end
    endtask

    task automatic test_abort();
        int w0 = n_wr;
        int d0 = n_done;
        logic [7:0] bytes [0:4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
        start_load(16'h0030, 16'd3);
        for (int i = 0; i < 5; i++) send_byte(bytes[i]);
        bus.ld_abort = 1'b1;
        step();
        bus.ld_abort = 1'b0;
        step();
        step();
        total++; if (bus.ld_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.ld_busy); end
        total++; if (n_wr - w0 !== 1) begin bad++; $display("FAIL abort_nwrites got=%0d exp=1", n_wr - w0); end
        total++; if (wa[w0] !== 16'h0030 || wd[w0] !== 32'h11223344) begin bad++; $display("FAIL abort_wr0 got=%h:%h exp=0030:11223344", wa[w0], wd[w0]); end
        total++; if (n_done - d0 !== 0) begin bad++; $display("FAIL abort_ndone got=%0d exp=0", n_done - d0); end
        total++; if (bus.ld_count !== 16'd1) begin bad++; $display("FAIL abort_ld_count got=%h exp=0001", bus.ld_count); end
        // Fresh load must need a full four bytes and carry none of the 0x55 leftover.
        w0 = n_wr;
        start_load(16'h0040, 16'd1);
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        total++; if (n_wr - w0 !== 0) begin bad++; $display("FAIL abort_next_early_write got=%0d exp=0", n_wr - w0); end
        send_byte(8'hD4);
        wait_idle("abort_next");
        total++; if (n_wr - w0 !== 1) begin bad++; $display("FAIL abort_next_nwrites got=%0d exp=1", n_wr - w0); end
        total++; if (wa[w0] !== 16'h0040 || wd[w0] !== 32'hA1B2C3D4) begin bad++; $display("FAIL abort_next_wr got=%h:%h exp=0040:a1b2c3d4", wa[w0], wd[w0]); end
    endtask

    task automatic test_wrap_gaps();
        int w0 = n_wr;
        int d0 = n_done;
        start_load(16'hFFFF, 16'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.byte_ready !== 1'b1) begin bad++; $display("FAIL wrap_gap_ready%0d got=%b exp=1", i, bus.byte_ready); end
            step();
        end
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        wait_idle("wrap");
        total++; if (n_wr - w0 !== 2) begin bad++; $display("FAIL wrap_nwrites got=%0d exp=2", n_wr - w0); end
        total++; if (wa[w0] !== 16'hFFFF || wd[w0] !== 32'h01020304) begin bad++; $display("FAIL wrap_wr0 got=%h:%h exp=ffff:01020304", wa[w0], wd[w0]); end
        total++; if (wa[w0+1] !== 16'h0000 || wd[w0+1] !== 32'h05060708) begin bad++; $display("FAIL wrap_wr1 got=%h:%h exp=0000:05060708", wa[w0+1], wd[w0+1]); end
        total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL wrap_ndone got=%0d exp=1", n_done - d0); end
    endtask

    task automatic test_async_reset();
        int w0;
        int d0;
        start_load(16'h0050, 16'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        w0 = n_wr;
        d0 = n_done;
        #3;
        reset = 1'b0;
        #1;
        total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL arst_byte_ready got=%b exp=0", bus.byte_ready); end
        total++; if (bus.ld_busy !== 1'b0) begin bad++; $display("FAIL arst_ld_busy got=%b exp=0", bus.ld_busy); end
        total++; if (bus.ld_count !== 16'd0) begin bad++; $display("FAIL arst_ld_count got=%h exp=0000", bus.ld_count); end
        total++; if (bus.mem_datain !== 32'h0) begin bad++; $display("FAIL arst_word got=%h exp=00000000", bus.mem_datain); end
        bus.byte_valid = 1'b1;
        bus.byte_data = 8'h99;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) step();
        bus.byte_valid = 1'b0;
        total++; if (n_wr - w0 !== 0) begin bad++; $display("FAIL arst_nwrites got=%0d exp=0", n_wr - w0); end
        total++; if (n_done - d0 !== 0) begin bad++; $display("FAIL arst_ndone got=%0d exp=0", n_done - d0); end
        total++; if (bus.ld_busy !== 1'b0) begin bad++; $display("FAIL arst_idle got=%b exp=0", bus.ld_busy); end
    endtask

    initial begin
        test_reset();
        test_load2();
        test_zero_len();
        test_abort();
        test_wrap_gaps();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instmem_loader_ctrl.md
Name: instmem_loader_ctrl

Overview:
- Sequences the instruction memory between two users: the fetch path (read-only) and a program loader (write).
- The loader receives a byte stream, assembles it into instruction words and writes them to consecutive instruction-memory addresses.
- Fetch is stalled for the whole duration of a load.
- Sits between the fetch stage, the external boot/debug byte source, and the single-port instruction memory: 16-bit address, 32-bit data, combinational read, synchronous write.

Parameters:
- ADDR_W, 16, instruction-memory address width.
- DATA_W, 32, instruction word width; must be a multiple of 8.
- BIG_ENDIAN, 1, 1 = first received byte lands in bits [DATA_W-1:DATA_W-8]; 0 = first byte lands in bits [7:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch requests a read.
- f_addr  in  ADDR_W  fetch address.
- f_data  out  DATA_W  fetched word; valid when f_ready=1.
- f_ready  out  1  fetch read serviced this cycle.
- ld_start  in  1  start-load pulse.
- ld_abort  in  1  abort current load.
- ld_base  in  ADDR_W  first word address, sampled on accepted ld_start.
- ld_len  in  ADDR_W  word count, sampled on accepted ld_start.
- byte_valid  in  1  byte_data valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  controller accepts a byte this cycle.
- ld_busy  out  1  load in progress (state != IDLE).
- ld_done  out  1  one-cycle pulse on load completion.
- ld_count  out  ADDR_W  words written in current or last load.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_datain  out  DATA_W  memory write data.
- mem_dataout  in  DATA_W  memory read data.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; byte index=0; word register=0; ld_count=0.
  - Outputs at reset: mem_write=0, ld_done=0, ld_busy=0, byte_ready=0, f_ready=0.
  - A partially assembled word is discarded.
  - Words already written stay in memory.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - f_ready=f_req; mem_addr=f_addr; f_data=mem_dataout, giving zero-latency reads.
  - ld_start=1: latch ld_base and ld_len; clear ld_count and byte index.
  - If ld_len==0, go to DONE; otherwise go to COLLECT.
- COLLECT:
  - byte_ready=1; f_ready=0.
  - On byte_valid, shift byte_data into the word register in the order set by BIG_ENDIAN, and increment byte index.
  - When the DATA_W/8-th byte is accepted, go to WRITE.
  - byte_valid=0 holds the state.
- WRITE: exactly one cycle.
  - mem_write=1; mem_addr=base+ld_count (modulo 2^ADDR_W, wraps 0xFFFF to 0x0000); mem_datain=word register.
  - byte_ready=0; f_ready=0.
  - Next edge: ld_count increments and byte index clears.
  - If the new ld_count==len, go to DONE; otherwise go to COLLECT.
- DONE: ld_done=1 for one cycle, then IDLE. ld_count holds until the next accepted ld_start.
- ld_start is ignored outside IDLE.
- ld_abort:
  - In COLLECT: go to IDLE; partial word discarded; no ld_done.
  - In WRITE: that write completes, then go to IDLE; no ld_done.
  - In IDLE or DONE: ignored.
  - ld_abort and ld_start in the same IDLE cycle: start wins.
- When not in WRITE: mem_write=0, mem_addr=f_addr, mem_datain=word register.
- f_data always equals mem_dataout; it is meaningful only when f_ready=1.

Test Plan:
- Load of 2 words: reset, ld_base=0x0010, ld_len=2, bytes 6F 7A 00 0A D8 3B C0 00 (BIG_ENDIAN=1).
  - Expect mem_write at addr 0x0010 with data 0x6F7A000A, then addr 0x0011 with data 0xD83BC000.
  - Expect ld_done one cycle after the second write, and ld_count=2.
- Fetch stall: f_req=1 throughout the load above.
  - Expect f_ready=0 from the cycle after ld_start until DONE.
  - Expect f_ready=1 again in IDLE with f_data = mem_dataout at f_addr.
- Zero-length load: ld_len=0 gives IDLE→DONE→IDLE, ld_done pulse, no mem_write, byte_ready never 1.
- Abort: ld_len=3; send 5 bytes, then assert ld_abort.
  - Expect exactly one write, then IDLE, no ld_done, ld_count=1.
  - Expect the next load to start with an empty word register.
- Address wrap and gaps: ld_base=0xFFFF, ld_len=2, with byte_valid deasserted for 3 cycles mid-word.
  - Expect writes at 0xFFFF and 0x0000, with byte_ready held 1 during the gaps.
- Async reset mid-COLLECT: after 2 bytes, pulse reset low off the clock edge.
  - Expect outputs to go to reset values immediately and no further mem_write.
